// File: rtl/clock_divider.sv
// ============================================================================
// clock_divider
// ----------------------------------------------------------------------------
// Free-running integer clock divider used as the UART baud-rate generator.
// The system clock is divided by DIVISOR to produce a near-50% duty-cycle
// slow clock plus a one-cycle strobe on the last cycle of every slow period.
// With the default DIVISOR of 651 and a 100 MHz system clock this gives the
// 16x oversampling clock for 9600 baud.
//
// Parameters:
//   DIVISOR  full period of clk_out in clk cycles (must be >= 2)
//   CNT_W    width of the internal cycle counter (derived, leave alone)
//
// Ports:
//   clk      input   system clock, all state changes on its rising edge
//   rst_n    input   asynchronous active-low reset
//   clk_out  output  divided clock, low for floor(DIVISOR/2) cycles then
//                    high for the remainder of the period; driven by a flop
//   tick     output  one-clk-cycle strobe on the last high cycle of clk_out;
//                    driven by a flop
//
// clk_out is a data signal. Downstream logic should use tick as a clock
// enable, or route clk_out through a global clock buffer before using it
// as a clock.
// ============================================================================
module clock_divider #(
    parameter int DIVISOR = 651,
    parameter int CNT_W   = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out,
    output logic tick
);

    // A divisor below 2 cannot produce both a low and a high phase.
    if (DIVISOR < 2) begin : g_badDivisor
        $error("clock_divider: DIVISOR must be at least 2");
    end

    // Counter value on the last cycle of a period, and the first value of
    // the high phase. Odd divisors therefore get the extra cycle high.
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] COUNT_HIGH = CNT_W'(DIVISOR / 2);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_countNext;

    // Next counter value. Using >= rather than == means any out-of-range
    // value (for example after an upset) falls back to 0 on the next edge.
    always_comb begin
        w_countNext = r_count + CNT_W'(1);
        if (r_count >= COUNT_LAST) begin
            w_countNext = '0;
        end
    end

    // Both outputs are decoded from the next counter value and registered,
    // so each output always reflects the counter value it sits beside and
    // there is no combinational path to the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            r_count <= w_countNext;
            clk_out <= (w_countNext >= COUNT_HIGH);
            tick    <= (w_countNext == COUNT_LAST);
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// ============================================================================
// tb_clock_divider
// ----------------------------------------------------------------------------
// Directed testbench for clock_divider. Four copies share one clock and
// reset: the default divisor 651 and the small corners 2, 4 and 5. Edges are
// numbered from reset release (edge 1 is the first rising clk edge after
// release), so on edge e each copy holds count = e mod DIVISOR.
// ============================================================================
module tb_clock_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic clkOut651, tick651;
    logic clkOut2,   tick2;
    logic clkOut4,   tick4;
    logic clkOut5,   tick5;

    int nTests  = 0;
    int nFailed = 0;

    // Accumulators for the default divisor and the corners
    int ticks651, ticks2, ticks4, ticks5;
    int highs651, highs2, highs4, highs5;
    int firstRise651, firstFall651;
    logic prev651;

    clock_divider #(.DIVISOR(651)) u_div651 (
        .clk(clk), .rst_n(rst_n), .clk_out(clkOut651), .tick(tick651)
    );
    clock_divider #(.DIVISOR(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .clk_out(clkOut2), .tick(tick2)
    );
    clock_divider #(.DIVISOR(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .clk_out(clkOut4), .tick(tick4)
    );
    clock_divider #(.DIVISOR(5)) u_div5 (
        .clk(clk), .rst_n(rst_n), .clk_out(clkOut5), .tick(tick5)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nTests++;
        assert (observed === expected) else begin
            nFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected outputs on edge e for divisor d
    function automatic int expClk(input int e, input int d);
        return ((e % d) >= (d / 2)) ? 1 : 0;
    endfunction

    function automatic int expTick(input int e, input int d);
        return ((e % d) == (d - 1)) ? 1 : 0;
    endfunction

    task automatic clearStats();
        ticks651 = 0; ticks2 = 0; ticks4 = 0; ticks5 = 0;
        highs651 = 0; highs2 = 0; highs4 = 0; highs5 = 0;
        firstRise651 = -1;
        firstFall651 = -1;
        prev651 = 1'b0;
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, " clk_out651"}, int'(clkOut651), 0);
        checkOutput({tag, " tick651"},    int'(tick651),   0);
        checkOutput({tag, " clk_out2"},   int'(clkOut2),   0);
        checkOutput({tag, " tick2"},      int'(tick2),     0);
        checkOutput({tag, " clk_out4"},   int'(clkOut4),   0);
        checkOutput({tag, " tick4"},      int'(tick4),     0);
        checkOutput({tag, " clk_out5"},   int'(clkOut5),   0);
        checkOutput({tag, " tick5"},      int'(tick5),     0);
    endtask

    // Advance through edges firstEdge..lastEdge, sampling 1 ns after each
    // rising edge and comparing every output against its expected value.
    task automatic applyStimulus(input int firstEdge, input int lastEdge);
        for (int e = firstEdge; e <= lastEdge; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("clk_out651@%0d", e), int'(clkOut651), expClk(e, 651));
            checkOutput($sformatf("tick651@%0d", e),    int'(tick651),   expTick(e, 651));
            checkOutput($sformatf("clk_out2@%0d", e),   int'(clkOut2),   expClk(e, 2));
            checkOutput($sformatf("tick2@%0d", e),      int'(tick2),     int'(clkOut2));
            checkOutput($sformatf("clk_out4@%0d", e),   int'(clkOut4),   expClk(e, 4));
            checkOutput($sformatf("tick4@%0d", e),      int'(tick4),     expTick(e, 4));
            checkOutput($sformatf("clk_out5@%0d", e),   int'(clkOut5),   expClk(e, 5));
            checkOutput($sformatf("tick5@%0d", e),      int'(tick5),     expTick(e, 5));
            if (clkOut651 && !prev651 && firstRise651 < 0) firstRise651 = e;
            if (!clkOut651 && prev651 && firstFall651 < 0) firstFall651 = e;
            prev651 = clkOut651;
            ticks651 += int'(tick651);
            ticks2   += int'(tick2);
            ticks4   += int'(tick4);
            ticks5   += int'(tick5);
            highs651 += int'(clkOut651);
            highs2   += int'(clkOut2);
            highs4   += int'(clkOut4);
            highs5   += int'(clkOut5);
        end
    endtask

    initial begin
        // Reset held for 5 cycles: all outputs low throughout
        clearStats();
        #1;
        checkAllLow("por_async");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkAllLow($sformatf("por_cycle%0d", i));
        end

        // Release between edges, then run three full default periods
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1953);

        checkOutput("first_rise651", firstRise651, 325);
        checkOutput("first_fall651", firstFall651, 651);
        checkOutput("ticks651_3per", ticks651, 3);
        checkOutput("highs651_3per", highs651, 978);
        checkOutput("ticks2_1953",   ticks2,   977);
        checkOutput("highs2_1953",   highs2,   977);
        checkOutput("ticks4_1953",   ticks4,   488);
        checkOutput("highs4_1953",   highs4,   976);
        checkOutput("ticks5_1953",   ticks5,   390);
        checkOutput("highs5_1953",   highs5,   1172);

        // Run to count = 500 in the default copy, where clk_out is high
        applyStimulus(1954, 2453);
        checkOutput("mid_clk_out651_high", int'(clkOut651), 1);

        // Assert reset between edges: outputs must drop with no clk edge
        #3;
        rst_n = 1'b0;
        #1;
        checkAllLow("mid_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkAllLow($sformatf("mid_hold%0d", i));
        end

        // After release the timing restarts exactly as after power-up
        clearStats();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 651);

        checkOutput("rerun_first_rise651", firstRise651, 325);
        checkOutput("rerun_first_fall651", firstFall651, 651);
        checkOutput("rerun_ticks651",      ticks651,     1);
        checkOutput("rerun_highs651",      highs651,     326);
        checkOutput("rerun_ticks5",        ticks5,       130);

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Free-running integer clock divider/baud-rate generator for the UART datapath.
- Divides the system clock by a fixed parameterised ratio to produce a near-50% duty-cycle slow clock, `clk_out`, plus a one-cycle wrap strobe.
- The default ratio of 651 gives the 16x oversampling clock for 9600 baud from a 100 MHz system clock.

Parameters:
- DIVISOR, 651: full period of `clk_out` in `clk` cycles. Legal range is DIVISOR ≥ 2; an elaboration-time check rejects smaller values.
- CNT_W, $clog2(DIVISOR): width of the internal cycle counter. It is derived, and not overridden in normal use.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_out  output  1  divided clock; registered, glitch-free.
- tick  output  1  one-`clk`-cycle strobe marking the last cycle of each `clk_out` period; registered.

Behaviour:
- One clock domain (`clk`). Reset is asynchronous and active-low (`rst_n`). No other inputs.
- Internal counter `count[CNT_W-1:0]`:
  - on each rising edge, `count <= (count == DIVISOR-1) ? 0 : count + 1`;
  - it wraps from DIVISOR-1 to 0 with no dead cycle.
- Reset:
  - while `rst_n` = 0, regardless of `clk`: `count` = 0, `clk_out` = 0, `tick` = 0;
  - assertion takes effect immediately, with no clock edge needed;
  - after deassertion, counting starts at the first rising edge.
- `clk_out` is a register whose value always equals `(count >= DIVISOR/2)`, where DIVISOR/2 is integer (floor) division:
  - it is set on the edge where `count` goes DIVISOR/2-1 → DIVISOR/2;
  - it is cleared on the edge where `count` wraps DIVISOR-1 → 0.
- Resulting duty cycle:
  - low phase = floor(DIVISOR/2) cycles; high phase = DIVISOR - floor(DIVISOR/2) cycles;
  - odd DIVISOR puts the extra cycle in the high phase;
  - default 651: low 325, high 326.
- First edge after reset: the first rising edge of `clk_out` occurs at the floor(DIVISOR/2)-th rising `clk` edge after reset release (edge 325 for the default).
- `tick`:
  - a register whose value always equals `(count == DIVISOR-1)`;
  - high for exactly one `clk` cycle per period, the last high cycle of `clk_out`;
  - it falls on the same edge that `clk_out` falls.
- Both outputs come straight from flops, so there is no combinational path from inputs to outputs. `clk_out` must not drive clock pins directly in synthesis; downstream logic uses it as a clock only via a global buffer, or uses `tick` as an enable.
- DIVISOR = 2: `clk_out` toggles every cycle (1 low, 1 high), and `tick` = `clk_out`.
- Reset mid-period: `count`, `clk_out` and `tick` drop to 0 asynchronously. The next period after release is a full, clean period with the same timing as after power-up reset.
- Counter arithmetic never exceeds DIVISOR-1, so there is no overflow at CNT_W bits. Any out-of-range `count` (e.g. from an upset) returns to 0 on the next edge; implement this as `count >= DIVISOR-1` → 0.

Test Plan:
- Reset values: hold `rst_n` = 0 for 5 `clk` cycles at 100 MHz → `clk_out` = 0, `tick` = 0 throughout.
- First rise: release `rst_n` → `clk_out` stays 0 for edges 1-324, rises at edge 325, and its first fall is at edge 651.
- Period and duty (default 651): run 3 periods → every period is 651 `clk` cycles, low 325, high 326. `tick` is high exactly 1 cycle per period, on the cycle before each `clk_out` fall, with 3 pulses total.
- Async reset mid-operation: assert `rst_n` = 0 between clock edges while `clk_out` = 1 and `count` ≈ 500 → `clk_out` and `tick` go 0 before the next `clk` edge. After release, the rise again comes at edge 325.
- Parameter corners:
  - DIVISOR = 2 → `clk_out` = 0,1,0,1… and `tick` matches `clk_out`;
  - DIVISOR = 5 → low 2, high 3, `tick` once per 5 cycles;
  - DIVISOR = 4 → low 2, high 2.
- Long run: 10,000 `clk_out` periods at default → zero period or duty deviations, and `tick` count equals the `clk_out` falling-edge count.
